// File: rtl/riscv_icache.sv
// Direct-mapped read-only instruction cache: 1-cycle hit, word-by-word refill on miss.
// stall_o freezes fetch from miss detection through the last refill ack.
module riscv_icache #(
    parameter int LINES          = 16,
    parameter int WORDS_PER_LINE = 4,
    parameter int ADDR_W         = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] inst_cache_a,
    input  logic              inst_cache_ren,
    output logic [31:0]       inst_cache_d,
    output logic              stall_o,
    input  logic              flush_i,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_ack_i,
    input  logic [31:0]       mem_data_i,
    output logic [31:0]       miss_count_o
);

    localparam int OFF   = $clog2(WORDS_PER_LINE);
    localparam int IDX   = $clog2(LINES);
    localparam int TAG_W = ADDR_W - OFF - IDX - 2;
    localparam logic [OFF-1:0] CNT_LAST = OFF'(WORDS_PER_LINE - 1);

    typedef enum logic [1:0] {S_LOOKUP, S_REFILL, S_RESUME} state_t;

    state_t              r_state;
    state_t              w_next;
    logic [ADDR_W-1:0]   r_a_q;
    logic                r_lookup_v;
    logic [LINES-1:0]    r_valid;
    logic [TAG_W-1:0]    r_tag  [LINES];
    logic [31:0]         r_data [LINES*WORDS_PER_LINE];
    logic [OFF-1:0]      r_cnt;
    logic                r_flush_pend;
    logic [31:0]         r_miss_count;
    logic [31:0]         r_inst_d;
    logic [31:0]         r_fwd;

    logic [OFF-1:0]      w_word;
    logic [IDX-1:0]      w_idx;
    logic [TAG_W-1:0]    w_tag;
    logic                w_hit;
    logic                w_miss;
    logic                w_ack;
    logic                w_last_ack;
    logic                w_stall;
    logic                w_mem_req;
    logic [ADDR_W-1:0]   w_mem_addr;
    logic [31:0]         w_inst_d;
    logic                w_unused_ok;

    assign w_word      = r_a_q[OFF+1:2];
    assign w_idx       = r_a_q[OFF+IDX+1:OFF+2];
    assign w_tag       = r_a_q[ADDR_W-1:OFF+IDX+2];
    assign w_unused_ok = ^r_a_q[1:0];

    assign w_hit      = r_lookup_v & r_valid[w_idx] & (r_tag[w_idx] == w_tag);
    assign w_miss     = (r_state == S_LOOKUP) & r_lookup_v & ~w_hit;
    assign w_ack      = (r_state == S_REFILL) & mem_ack_i;
    assign w_last_ack = w_ack & (r_cnt == CNT_LAST);

    always_comb begin
        w_next     = r_state;
        w_stall    = 1'b0;
        w_mem_req  = 1'b0;
        w_mem_addr = '0;
        w_inst_d   = r_inst_d;
        case (r_state)
            S_LOOKUP: begin
                if (w_hit) begin
                    w_inst_d = r_data[{w_idx, w_word}];
                end else if (r_lookup_v) begin
                    w_stall = 1'b1;
                    w_next  = S_REFILL;
                end
            end
            S_REFILL: begin
                w_stall    = 1'b1;
                w_mem_req  = 1'b1;
                w_mem_addr = {w_tag, w_idx, r_cnt, 2'b00};
                if (w_last_ack) begin
                    w_next = S_RESUME;
                end
            end
            S_RESUME: begin
                // The refilled word comes from r_fwd so a pending flush cannot hide it.
                w_inst_d = r_fwd;
                w_next   = S_LOOKUP;
            end
            default: w_next = S_LOOKUP;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state      <= S_LOOKUP;
            r_a_q        <= '0;
            r_lookup_v   <= 1'b0;
            r_valid      <= '0;
            r_cnt        <= '0;
            r_flush_pend <= 1'b0;
            r_miss_count <= '0;
            r_inst_d     <= '0;
        end else begin
            r_state  <= w_next;
            r_inst_d <= w_inst_d;
            if (!w_stall) begin
                r_a_q      <= inst_cache_a;
                r_lookup_v <= inst_cache_ren;
            end
            if (w_miss) begin
                r_miss_count <= r_miss_count + 32'd1;
                r_cnt        <= '0;
            end
            if (w_ack) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (r_state != S_REFILL) begin
                if (flush_i) begin
                    r_valid <= '0;
                end
            end else begin
                if (flush_i) begin
                    r_flush_pend <= 1'b1;
                end
                if (w_last_ack) begin
                    if (r_flush_pend || flush_i) begin
                        r_valid      <= '0;
                        r_flush_pend <= 1'b0;
                    end else begin
                        r_valid[w_idx] <= 1'b1;
                    end
                end
            end
        end
    end

    // Storage arrays carry no reset; the valid bits alone qualify them.
    always_ff @(posedge clk_i) begin
        if (w_ack) begin
            r_data[{w_idx, r_cnt}] <= mem_data_i;
            if (r_cnt == w_word) begin
                r_fwd <= mem_data_i;
            end
        end
        if (w_last_ack) begin
            r_tag[w_idx] <= w_tag;
        end
    end

    assign inst_cache_d = w_inst_d;
    assign stall_o      = w_stall;
    assign mem_req_o    = w_mem_req;
    assign mem_addr_o   = w_mem_addr;
    assign miss_count_o = r_miss_count;

endmodule

// File: tb/tb_riscv_icache.sv
// Directed bench for riscv_icache: cold miss, hits, eviction, slow memory, flush, reset mid-refill.
module tb_riscv_icache;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] inst_cache_a;
    logic        inst_cache_ren;
    logic [31:0] inst_cache_d;
    logic        stall_o;
    logic        flush_i;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_ack_i;
    logic [31:0] mem_data_i;
    logic [31:0] miss_count_o;

    int n_cmp = 0;
    int n_err = 0;

    riscv_icache #(.LINES(16), .WORDS_PER_LINE(4), .ADDR_W(32)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .inst_cache_a   (inst_cache_a),
        .inst_cache_ren (inst_cache_ren),
        .inst_cache_d   (inst_cache_d),
        .stall_o        (stall_o),
        .flush_i        (flush_i),
        .mem_req_o      (mem_req_o),
        .mem_addr_o     (mem_addr_o),
        .mem_ack_i      (mem_ack_i),
        .mem_data_i     (mem_data_i),
        .miss_count_o   (miss_count_o)
    );

    always #5 clk_i = ~clk_i;

    // Backing memory contents: 0x2800 -> 0x13, 0x2804 -> 0x17, ...
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a + 32'h13 - 32'h2800;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // Issues one fetch expected to miss, serves the refill acking every 'period' cycles,
    // optionally pulses flush_i at word 'flush_at', then checks the RESUME word.
    task automatic fetch_miss(input logic [31:0] addr, input int period, input int flush_at,
                              input logic [31:0] exp_d);
        logic [31:0] base;
        logic [31:0] waddr;
        base           = addr & 32'hFFFF_FFF0;
        inst_cache_a   = addr;
        inst_cache_ren = 1'b1;
        @(negedge clk_i);
        chk("miss_stall", 32'(stall_o), 32'd1);
        chk("miss_noreq", 32'(mem_req_o), 32'd0);
        inst_cache_ren = 1'b0;
        for (int k = 0; k < 4; k++) begin
            waddr = base + 32'(4 * k);
            for (int w = 0; w < period; w++) begin
                @(negedge clk_i);
                chk("refill_req", 32'(mem_req_o), 32'd1);
                chk("refill_addr", mem_addr_o, waddr);
                chk("refill_stall", 32'(stall_o), 32'd1);
                flush_i = (k == flush_at) && (w == 0);
                if (w == period - 1) begin
                    mem_ack_i  = 1'b1;
                    mem_data_i = mem_word(waddr);
                end else begin
                    mem_ack_i  = 1'b0;
                    mem_data_i = 32'hDEAD_BEEF;
                end
            end
        end
        @(negedge clk_i);
        mem_ack_i  = 1'b0;
        mem_data_i = 32'hDEAD_BEEF;
        flush_i    = 1'b0;
        chk("resume_stall", 32'(stall_o), 32'd0);
        chk("resume_req", 32'(mem_req_o), 32'd0);
        chk("resume_data", inst_cache_d, exp_d);
    endtask

    initial begin
        rst_i          = 1'b1;
        inst_cache_a   = 32'h0;
        inst_cache_ren = 1'b0;
        flush_i        = 1'b0;
        mem_ack_i      = 1'b0;
        mem_data_i     = 32'hDEAD_BEEF;
        @(negedge clk_i);
        @(negedge clk_i);
        chk("rst_stall", 32'(stall_o), 32'd0);
        chk("rst_req", 32'(mem_req_o), 32'd0);
        chk("rst_addr", mem_addr_o, 32'h0);
        chk("rst_inst", inst_cache_d, 32'h0);
        chk("rst_cnt", miss_count_o, 32'h0);
        rst_i = 1'b0;

        // Cold miss followed by a back-to-back hit stream on the same line.
        fetch_miss(32'h2800, 1, -1, 32'h13);
        chk("cold_cnt", miss_count_o, 32'd1);
        inst_cache_a = 32'h2804; inst_cache_ren = 1'b1;
        @(negedge clk_i);
        chk("hit1_d", inst_cache_d, 32'h17);
        chk("hit1_stall", 32'(stall_o), 32'd0);
        inst_cache_a = 32'h2808;
        @(negedge clk_i);
        chk("hit2_d", inst_cache_d, 32'h1B);
        inst_cache_a = 32'h280C;
        @(negedge clk_i);
        chk("hit3_d", inst_cache_d, 32'h1F);
        chk("hit3_stall", 32'(stall_o), 32'd0);
        inst_cache_ren = 1'b0;
        inst_cache_a   = 32'h2900;
        @(negedge clk_i);
        chk("idle_hold_d", inst_cache_d, 32'h1F);
        chk("idle_stall", 32'(stall_o), 32'd0);
        chk("hit_cnt", miss_count_o, 32'd1);

        // Conflict eviction on index 0.
        fetch_miss(32'h2900, 1, -1, 32'h113);
        fetch_miss(32'h2800, 1, -1, 32'h13);
        chk("evict_cnt", miss_count_o, 32'd3);

        // Slow memory, line at index 1.
        fetch_miss(32'h2A18, 3, -1, 32'h22B);
        chk("slow_cnt", miss_count_o, 32'd4);

        // Flush on a hit cycle: the hit still returns, the next lookup misses.
        inst_cache_a = 32'h2808; inst_cache_ren = 1'b1;
        @(negedge clk_i);
        chk("flushhit_d", inst_cache_d, 32'h1B);
        chk("flushhit_stall", 32'(stall_o), 32'd0);
        flush_i = 1'b1; inst_cache_ren = 1'b0;
        @(negedge clk_i);
        flush_i = 1'b0;
        fetch_miss(32'h2800, 1, 1, 32'h13);
        chk("flushref_cnt", miss_count_o, 32'd5);
        fetch_miss(32'h2800, 1, -1, 32'h13);
        chk("postflush_cnt", miss_count_o, 32'd6);

        // Reset in the middle of a refill of 0x2900.
        inst_cache_a = 32'h2900; inst_cache_ren = 1'b1;
        @(negedge clk_i);
        chk("rmid_stall", 32'(stall_o), 32'd1);
        inst_cache_ren = 1'b0;
        @(negedge clk_i);
        mem_ack_i = 1'b1; mem_data_i = mem_word(32'h2900);
        @(negedge clk_i);
        mem_data_i = mem_word(32'h2904);
        @(negedge clk_i);
        chk("rmid_addr", mem_addr_o, 32'h2908);
        mem_ack_i = 1'b0;
        rst_i     = 1'b1;
        #1;
        chk("rmid_req", 32'(mem_req_o), 32'd0);
        chk("rmid_stall0", 32'(stall_o), 32'd0);
        chk("rmid_cnt", miss_count_o, 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        fetch_miss(32'h2800, 1, -1, 32'h13);
        chk("rafter_cnt", miss_count_o, 32'd1);
        fetch_miss(32'h2904, 1, -1, 32'h117);
        chk("partial_cnt", miss_count_o, 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
